mmio_uart_tx: RTL

Memory-mapped UART transmitter on the processor data bus, downstream of the core's store port (data address, write data, write enable).
- Decodes stores to its register window and queues bytes in a small FIFO.
- Serialises the queued bytes on tx_o as 8N1 frames.
- Exposes a status word for core loads, so firmware can poll before writing.

---
 rtl/mmio_uart_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-fed UART transmitter (TXDATA/STATUS/CTRL at BASE_ADDR+0/4/8; in: data_adr_i, write_data_i, mem_write_i; out: rd_data_o, tx_o), FIFO + 8N1 serialiser, define UART_TX_PARITY_EN for an even-parity bit
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int FIFO_DEPTH = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_adr_i,
  input  logic [31:0] write_data_i,
  input  logic        mem_write_i,
  output logic [31:0] rd_data_o,
  output logic        tx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [15:0] div, div_q, tmr;
  logic [7:0] shr;
  logic [2:0] idx;
  logic tx_q, ovf;
  logic sel_tx, sel_st, sel_ct, full, empty, last, pop, wr_tx, push;
  logic unused_ok;
  assign sel_tx = data_adr_i[31:2] == BASE_ADDR[31:2];
  assign sel_st = data_adr_i[31:2] == BASE_ADDR[31:2] + 30'd1;
  assign sel_ct = data_adr_i[31:2] == BASE_ADDR[31:2] + 30'd2;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign last = tmr == div_q - 16'd1;
  assign pop = !empty && (state == IDLE || (state == STOP && last));
  assign wr_tx = mem_write_i && sel_tx;
  assign push = wr_tx && (!full || pop);
  assign tx_o = tx_q;
  assign unused_ok = ^{data_adr_i[1:0], write_data_i[31:16]};
  always_comb
    rd_data_o = sel_st ? {16'b0, 8'(cnt), 3'b0, PAR_EN, ovf, state != IDLE, empty, full} :
                sel_ct ? {16'b0, div} : 32'b0;
  always_ff @(posedge clk_i)
    if (push) mem[wp] <= write_data_i[7:0];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      div <= 16'(CLKS_PER_BIT);
      div_q <= '0;
      tmr <= '0;
      idx <= '0;
      shr <= '0;
      tx_q <= 1'b1;
      state <= IDLE;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (push != pop) cnt <= push ? cnt + CW'(1) : cnt - CW'(1);
      if (wr_tx && full && !pop) ovf <= 1'b1;
      else if (mem_write_i && sel_st && write_data_i[3]) ovf <= 1'b0;
      if (mem_write_i && sel_ct) div <= write_data_i[15:0] == 16'd0 ? 16'd1 : write_data_i[15:0];
      if (pop) begin
        shr <= mem[rp];
        div_q <= div;
      end
      tmr <= (state == IDLE || last) ? 16'd0 : tmr + 16'd1;
      case (state)
        IDLE: if (!empty) begin
          state <= START;
          tx_q <= 1'b0;
        end
        START: if (last) begin
          state <= DATA;
          idx <= 3'd0;
          tx_q <= shr[0];
        end
        DATA: if (last) begin
          idx <= idx + 3'd1;
          state <= idx != 3'd7 ? DATA : PAR_EN ? PARITY : STOP;
          tx_q <= idx != 3'd7 ? shr[idx + 3'd1] : PAR_EN ? ^shr : 1'b1;
        end
        PARITY: if (last) begin
          state <= STOP;
          tx_q <= 1'b1;
        end
        STOP: if (last) begin
          state <= empty ? IDLE : START;
          tx_q <= empty;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
